poly_stream_feeder: RTL

- Driving end of the serial coefficient-stream protocol used by the polynomial arithmetic units (adder style: one `start` pulse, N coefficient pairs, fixed compute latency, N result words).
- Host preloads two N-coefficient polynomials into local buffers and pulses `go`.
- The block then issues `start_out` and streams coefficient pairs on `a_out`/`b_out`.
- It captures the returned `result_in` stream into a result buffer that the host reads back.

---
 rtl/poly_stream_feeder.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/poly_stream_feeder.sv
// Driving end of the serial coefficient-stream protocol: streams two preloaded
// polynomials to a consumer and captures its fixed-latency result stream.
module poly_stream_feeder #(
  parameter int unsigned N       = 1024,
  parameter int unsigned W       = 30,
  parameter int unsigned AW      = 10,
  parameter int unsigned RES_LAT = 2050
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_we,
  input  logic          ld_sel,
  input  logic [AW-1:0] ld_addr,
  input  logic [W-1:0]  ld_data,
  input  logic          go,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  output logic          busy,
  output logic          done,
  output logic          start_out,
  output logic [W-1:0]  a_out,
  output logic [W-1:0]  b_out,
  input  logic [W-1:0]  result_in
);

  localparam int unsigned CW = $clog2(RES_LAT + N + 1);

  // tc counts edges since edge 0; values below are tc as seen before an edge.
  // RES_LAT >= N+2 is assumed so that SEND always finishes before capture.
  localparam logic [CW-1:0] TC_SAT       = CW'(RES_LAT + N);
  localparam logic [CW-1:0] TC_SEND_LAST = CW'(N - 1);
  localparam logic [CW-1:0] TC_WAIT_END  = CW'(RES_LAT - 2);
  localparam logic [CW-1:0] TC_CAP0      = CW'(RES_LAT - 1);
  localparam logic [CW-1:0] TC_CAP_LAST  = CW'(RES_LAT + N - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SEND,
    S_WAIT,
    S_CAPTURE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [W-1:0]  r_mem_a [N];
  logic [W-1:0]  r_mem_b [N];
  logic [W-1:0]  r_mem_r [N];

  logic [CW-1:0] r_tc;
  logic          r_start;
  logic          r_busy;
  logic          r_done;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_rd_data;

  logic          w_start_next;
  logic          w_busy_next;
  logic          w_done_next;
  logic          w_tc_clr;
  logic          w_send_en;
  logic [AW-1:0] w_send_idx;
  logic          w_stream_clr;
  logic          w_cap_en;
  logic [AW-1:0] w_cap_idx;
  logic          w_ld_en;

  assign w_ld_en   = ld_we && (r_state == S_IDLE);
  assign w_cap_idx = AW'(r_tc - TC_CAP0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start_next = 1'b0;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;
    w_tc_clr     = 1'b0;
    w_send_en    = 1'b0;
    w_send_idx   = '0;
    w_stream_clr = 1'b0;
    w_cap_en     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (go) begin
          w_state_next = S_START;
          w_start_next = 1'b1;
          w_busy_next  = 1'b1;
        end
      end
      S_START: begin
        // This edge is edge 0: first pair goes out and the latency count begins.
        w_state_next = S_SEND;
        w_tc_clr     = 1'b1;
        w_send_en    = 1'b1;
        w_send_idx   = '0;
      end
      S_SEND: begin
        if (r_tc == TC_SEND_LAST) begin
          w_state_next = S_WAIT;
          w_stream_clr = 1'b1;
        end else begin
          w_send_en  = 1'b1;
          w_send_idx = AW'(r_tc + CW'(1));
        end
      end
      S_WAIT: begin
        if (r_tc >= TC_WAIT_END) begin
          w_state_next = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        w_cap_en = !reset;
        if (r_tc == TC_CAP_LAST) begin
          w_state_next = S_IDLE;
          w_busy_next  = 1'b0;
          w_done_next  = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_tc    <= '0;
    end else begin
      r_start <= w_start_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
      if (w_send_en) begin
        r_a <= r_mem_a[w_send_idx];
        r_b <= r_mem_b[w_send_idx];
      end else if (w_stream_clr) begin
        r_a <= '0;
        r_b <= '0;
      end
      if (w_tc_clr) begin
        r_tc <= '0;
      end else if (r_tc != TC_SAT) begin
        r_tc <= r_tc + CW'(1);
      end
    end
  end

  // Buffers carry no reset so they survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (w_ld_en && !ld_sel) begin
      r_mem_a[ld_addr] <= ld_data;
    end
    if (w_ld_en && ld_sel) begin
      r_mem_b[ld_addr] <= ld_data;
    end
    if (w_cap_en) begin
      r_mem_r[w_cap_idx] <= result_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem_r[rd_addr];
    end
  end

  assign start_out = r_start;
  assign busy      = r_busy;
  assign done      = r_done;
  assign a_out     = r_a;
  assign b_out     = r_b;
  assign rd_data   = r_rd_data;

endmodule
